// File: rtl/sram_controller.sv
// Bus-side responder for one asynchronous SRAM bank.
// Every SRAM pin is registered from the next state, so a pin's value always matches the current state.
module sram_controller #(
  parameter int RAM_ADDR_WIDTH = 20,
  parameter int READ_CYCLES    = 2,
  parameter int WE_CYCLES      = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic                      store,
  input  logic [31:0]               addr,
  input  logic [31:0]               wdata,
  input  logic [3:0]                byte_en,
  output logic [31:0]               rdata,
  output logic                      busy,
  inout  wire  [31:0]               ram_data,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [3:0]                ram_be_n,
  output logic                      ram_ce_n,
  output logic                      ram_oe_n,
  output logic                      ram_we_n
);

  localparam int MAX_CYCLES = (READ_CYCLES > WE_CYCLES) ? READ_CYCLES : WE_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, READ, W_SETUP, W_PULSE, W_HOLD, DONE} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]               wdata_q, wdata_d;
  logic [31:0]               rdata_q, rdata_d;
  logic [3:0]                be_q, be_d;
  logic                      ce_n_q, ce_n_d;
  logic                      oe_n_q, oe_n_d;
  logic                      we_n_q, we_n_d;
  logic [3:0]                be_n_q, be_n_d;
  logic                      drive_q, drive_d;
  logic                      pins_active;

  // Byte-offset and upper address bits are not part of the SRAM word address.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:RAM_ADDR_WIDTH+2], addr[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (store) begin
          addr_d  = addr[RAM_ADDR_WIDTH+1:2];
          wdata_d = wdata;
          be_d    = byte_en;
          state_d = W_SETUP;
        end else if (load) begin
          addr_d  = addr[RAM_ADDR_WIDTH+1:2];
          be_d    = byte_en;
          cnt_d   = CNT_W'(READ_CYCLES - 1);
          state_d = READ;
        end
      end
      READ: begin
        if (cnt_q == '0) begin
          rdata_d = ram_data;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      W_SETUP: begin
        cnt_d   = CNT_W'(WE_CYCLES - 1);
        state_d = W_PULSE;
      end
      W_PULSE: begin
        if (cnt_q == '0) state_d = W_HOLD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      W_HOLD:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pin values are derived from the state being entered so they register in lockstep with it.
    pins_active = state_d inside {READ, W_SETUP, W_PULSE, W_HOLD};
    ce_n_d      = !pins_active;
    oe_n_d      = (state_d != READ);
    we_n_d      = (state_d != W_PULSE);
    be_n_d      = pins_active ? ~be_d : 4'hF;
    drive_d     = state_d inside {W_SETUP, W_PULSE, W_HOLD};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      be_n_q  <= 4'hF;
      drive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      be_n_q  <= be_n_d;
      drive_q <= drive_d;
    end
  end

  // High in the request's first cycle so the bus never sees a false completion.
  assign busy = ((state_q == IDLE) && (load || store)) ||
                (state_q inside {READ, W_SETUP, W_PULSE, W_HOLD});

  assign ram_data = drive_q ? wdata_q : {32{1'bz}};
  assign ram_addr = addr_q;
  assign ram_be_n = be_n_q;
  assign ram_ce_n = ce_n_q;
  assign ram_oe_n = oe_n_q;
  assign ram_we_n = we_n_q;
  assign rdata    = rdata_q;

endmodule
